// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, data and shared-memory signals of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// surrounding fetch/data clients and memory model.
interface mem_arbiter_if;
  // Fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  // Data side
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  // Shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  // Status
  logic        err;
  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_ready, mem_rdata,
    output if_ack, if_rdata,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output err, busy
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_ready, mem_rdata,
    input  if_ack, if_rdata,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  err, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester and a
// data requester. One access is in flight at a time; each access ends with a
// one-cycle ack to the granted side, optionally flagged err on memory timeout.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise the data side always wins a conflict.
module mem_arbiter #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_e;

`ifdef MEM_ARBITER_RR_EN
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  grant_e last_grant_q, last_grant_d;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             pick_d_c;

  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Next-state: request sampling/latching, completion, timeout and ack generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cnt_inc_c   = cnt_q + CNT_W'(1);
    pick_d_c    = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
`ifdef MEM_ARBITER_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Conflict resolution: round-robin favours the side not granted last.
        if (bus.d_req && bus.if_req) begin
`ifdef MEM_ARBITER_RR_EN
          pick_d_c = (last_grant_q == GNT_I);
`else
          pick_d_c = 1'b1;
`endif
        end else begin
          pick_d_c = bus.d_req;
        end

        if (bus.d_req || bus.if_req) begin
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (pick_d_c) begin
            state_d     = BUSY_D;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            state_d     = BUSY_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
`ifdef MEM_ARBITER_RR_EN
          last_grant_d = pick_d_c ? GNT_D : GNT_I;
`endif
        end
      end

      BUSY_I, BUSY_D: begin
        mem_req_d = 1'b1;
        if (bus.mem_ready) begin
          // Normal completion wins even on the cycle the wait budget runs out.
          state_d   = DONE;
          mem_req_d = 1'b0;
          err_d     = 1'b0;
          if (state_q == BUSY_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_inc_c == CNT_W'(WAIT_LIMIT)) begin
          // Wait budget exhausted: complete with error and zero data.
          state_d   = DONE;
          cnt_d     = cnt_inc_c;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any in-flight access silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Round-robin history; fetch counts as last granted out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= GNT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Drive interface outputs from their registers
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule
